pgcd_master: RTL
================

# pgcd_master

Initiator side of the PGCD core's `valid`/`ready` operand interface. It accepts 8-bit operand pairs from an upstream valid/ready stream, loads them into the PGCD core with a one-cycle `core_valid` pulse, and captures the result during the single cycle in which the core raises `ready`. It then presents the result on a downstream valid/ready stream. Zero operands, which the core never resolves, are handled locally, and a watchdog bounds every wait.

## Interface
- `TIMEOUT`, default 512: maximum number of WAIT cycles before the transaction is aborted with an error. Must be ≥ 2.
- `clk`  in  1  Clock. Every register updates on its rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `in_valid`  in  1  Upstream operand pair is valid.
- `in_ready`  out  1  Block can accept an operand pair. High only in IDLE.
- `in_a`, `in_b`  in  8  Operands.
- `core_valid`  out  1  Load strobe to the core's `valid`.
- `core_a`, `core_b`  out  8  Operands to the core's `a`/`b`. These come from registers.
- `core_ready`  in  1  The core's `ready`.
- `core_pgcd`  in  8  The core's `pgcd`.
- `out_valid`  out  1  Result is valid.
- `out_ready`  in  1  Downstream accepts the result.
- `out_pgcd`  out  8  The GCD result.
- `out_err`  out  1  The transaction timed out. `out_pgcd` = 0 in that case.

## Operation
- FSM states: IDLE, LOAD, WAIT, DONE. Reset state is IDLE.
- IDLE
  - `in_ready` = 1.
  - On `in_valid`, register `in_a`/`in_b`.
  - If either operand is 0: `out_pgcd` ← `in_a | in_b`, `out_err` ← 0, go to DONE. This bypass means gcd(0,x) = x and gcd(0,0) = 0. The core is not touched.
  - Otherwise go to LOAD.
- LOAD
  - `core_valid` = 1 for exactly one cycle, with `core_a`/`core_b` set to the registered operands.
  - Clear the WAIT counter, then go to WAIT.
- WAIT
  - `core_valid` = 0.
  - The core's `ready` is a one-cycle pulse: after equality the core collapses to min = 0. The block must therefore sample `core_pgcd` in the same cycle `core_ready` = 1.
  - When `core_ready` = 1: `out_pgcd` ← `core_pgcd`, `out_err` ← 0, go to DONE.
  - Otherwise, when the counter equals `TIMEOUT`−1: `out_pgcd` ← 0, `out_err` ← 1, go to DONE.
  - Otherwise increment the counter.
- DONE
  - `out_valid` = 1, with `out_pgcd`/`out_err` held stable.
  - On `out_ready`, go to IDLE.
- `core_valid` is 0 in every state except LOAD. Any other pulse would reload the core mid-computation.
- `core_ready` is ignored outside WAIT, including stale pulses left over from a previous or aborted computation.
- Counter width is `$clog2(TIMEOUT)`. It never wraps, because the terminal compare fires first.

## Timing
- Values after reset:
  - `in_ready` = 1 (combinational from IDLE).
  - `core_valid` = 0.
  - `core_a` = `core_b` = 0.
  - `out_valid` = 0, `out_pgcd` = 0, `out_err` = 0.
- Cycle numbering: cycle 0 is the edge with the input handshake.
- Normal path:
  - LOAD in cycle 1.
  - First WAIT cycle in cycle 2. In this cycle `core_ready` reflects the freshly loaded operands.
  - If the core needs N update edges, `core_ready` arrives in WAIT cycle N, and `out_valid` rises at cycle 3+N.
  - Equal operands give N = 0, so `out_valid` at cycle 3.
- Bypass path: `out_valid` rises at cycle 1.
- Timeout: `out_valid` rises at cycle 2+`TIMEOUT`, with `out_err` = 1.
- The output handshake completes on the edge where `out_valid` & `out_ready`. `in_ready` goes high the next cycle, so throughput is at most one pair per 2 cycles (bypass path).
- `core_ready` arriving in the same WAIT cycle that the counter reaches `TIMEOUT`−1: the result wins, and `out_err` = 0.
- Reset in any state returns to IDLE next cycle and drops `core_valid`/`out_valid`. The core may keep iterating internally; the next LOAD overrides it.

## Structure
- Shared package `pgcd_pkg`:
  - `PGCD_W` = 8.
  - `typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} pgcd_master_state_t`.
- No sub-module inside `pgcd_master`. It connects port-to-port to a PGCD core instance at the enclosing level.
- Test benches instantiate both the core and this block.

## Test plan
- (12, 18) → `out_pgcd` = 6, `out_err` = 0. Exactly one `core_valid` pulse.
- (7, 7) → `core_ready` in the first WAIT cycle. `out_pgcd` = 7, with `out_valid` at cycle 3.
- Zero operands:
  - (0, 9) → `out_pgcd` = 9 at cycle 1, `core_valid` never asserted.
  - (0, 0) → `out_pgcd` = 0, `out_err` = 0.
- (255, 1) with `TIMEOUT` = 512 → 254 WAIT cycles, then `out_pgcd` = 1.
- (255, 1) with `TIMEOUT` = 16 → `out_err` = 1, `out_pgcd` = 0.
- Timeout recovery: after the 16-cycle timeout above, the next pair (12, 18) still yields 6.
- Backpressure: (12, 18) with `out_ready` held low for 5 cycles → `out_valid`/`out_pgcd` stable and `in_ready` = 0 throughout.
- Reset asserted mid-WAIT → next cycle IDLE, `out_valid` = 0. A following (8, 12) → 4.

Source files
------------

// File: rtl/pgcd_pkg.sv
// Shared types and constants for the PGCD core initiator.
// Imported by pgcd_master and its surrounding fabric.
package pgcd_pkg;

  localparam int PGCD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE
  } pgcd_master_state_t;

endpackage

// File: rtl/pgcd_master.sv
// Initiator for the PGCD core: loads operand pairs, captures the
// single-cycle result pulse, bypasses zero operands, bounds the wait.
module pgcd_master
  import pgcd_pkg::*;
#(
  parameter int TIMEOUT = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PGCD_W-1:0] in_a,
  input  logic [PGCD_W-1:0] in_b,
  output logic              core_valid,
  output logic [PGCD_W-1:0] core_a,
  output logic [PGCD_W-1:0] core_b,
  input  logic              core_ready,
  input  logic [PGCD_W-1:0] core_pgcd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PGCD_W-1:0] out_pgcd,
  output logic              out_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  pgcd_master_state_t state;
  logic [CW-1:0]      cnt;

  // Only IDLE can take a new operand pair.
  assign in_ready = (state == IDLE);

  // Transaction FSM; every output except in_ready is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      core_valid <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
      out_valid  <= 1'b0;
      out_pgcd   <= '0;
      out_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            core_a <= in_a;
            core_b <= in_b;
            if (in_a == '0 || in_b == '0) begin
              out_pgcd  <= in_a | in_b;
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              core_valid <= 1'b1;
              state      <= LOAD;
            end
          end
        end
        LOAD: begin
          core_valid <= 1'b0;
          cnt        <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (core_ready) begin
            out_pgcd  <= core_pgcd;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (cnt == LAST) begin
            out_pgcd  <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
